// File: rtl/dsp48_pkg.sv
// Shared DSP48 slice definitions: OPMODE field positions, X/Z select encodings, datapath widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsp48_pkg;

    localparam int W_M = 36;
    localparam int W_P = 48;

    // OPMODE field positions; bits [6:4] have no meaning in the post-adder.
    localparam int OPM_X_LSB = 0;
    localparam int OPM_Z_LSB = 2;
    localparam int OPM_SUB   = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_t;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_t;

endpackage

// File: rtl/dsp_pipe_reg_n.sv
// Optional pipeline register: captures d when ce=1, holds otherwise; EN=0 passes d straight through.
// Latency: 1 cycle when EN=1, 0 cycles when EN=0.
// Backpressure: none; ce=0 simply holds the stored value (it is never cleared by ce).
// Ports: clk, rst_n (async active-low clear), ce (capture enable), d (input), q (output).
module dsp_pipe_reg_n #(
    parameter int WIDTH = 1,
    parameter bit EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (ce) begin
            r <= d;
        end
    end

    // With EN=0 the register is left dangling and is trimmed by synthesis.
    assign q = EN ? r : d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, add/sub with carry-in, P register.
// Latency: opmode/carryin -> p in OPMODEREG/CARRYINREG + PREG edges; m/dab/c/pcin -> p in PREG edges.
// Backpressure: none; each register holds while its ce is low.
// Ports: clk, rst_n; ce_opmode/ce_carryin/ce_p enables; opmode, m, dab, c, pcin, carryin operands;
//        p/pcout result and cascade, carryout/carryoutf carry (borrow when subtracting).
module dsp_post_adder_acc
    import dsp48_pkg::*;
#(
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1,
    parameter int PREG       = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce_opmode,
    input  logic           ce_carryin,
    input  logic           ce_p,
    input  logic [7:0]     opmode,
    input  logic [W_M-1:0] m,
    input  logic [W_P-1:0] dab,
    input  logic [W_P-1:0] c,
    input  logic [W_P-1:0] pcin,
    input  logic           carryin,
    output logic [W_P-1:0] p,
    output logic [W_P-1:0] pcout,
    output logic           carryout,
    output logic           carryoutf
);

    logic [7:0]     opmode_q;
    logic           carryin_q;
    x_sel_t         x_sel;
    z_sel_t         z_sel;
    logic           sub;
    logic [W_P-1:0] x_op;
    logic [W_P-1:0] z_op;
    logic [W_P:0]   sum_full;
    logic [W_P-1:0] p_r;
    logic           carryout_r;
    logic           unused_opmode_bits;

    dsp_pipe_reg_n #(.WIDTH(8), .EN(OPMODEREG != 0)) u_opmode_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_opmode),
        .d     (opmode),
        .q     (opmode_q)
    );

    dsp_pipe_reg_n #(.WIDTH(1), .EN(CARRYINREG != 0)) u_carryin_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_carryin),
        .d     (carryin),
        .q     (carryin_q)
    );

    assign x_sel              = x_sel_t'(opmode_q[OPM_X_LSB +: 2]);
    assign z_sel              = z_sel_t'(opmode_q[OPM_Z_LSB +: 2]);
    assign sub                = opmode_q[OPM_SUB];
    assign unused_opmode_bits = ^opmode_q[6:4];

    always_comb begin
        x_op = '0;
        unique case (x_sel)
            X_ZERO: x_op = '0;
            X_M:    x_op = {{(W_P-W_M){1'b0}}, m};  // zero-extended, m is unsigned here
            X_P:    x_op = p_r;
            X_DAB:  x_op = dab;
            default: x_op = '0;
        endcase
    end

    always_comb begin
        z_op = '0;
        unique case (z_sel)
            Z_ZERO: z_op = '0;
            Z_PCIN: z_op = pcin;
            Z_P:    z_op = p_r;
            Z_C:    z_op = c;
            default: z_op = '0;
        endcase
    end

    // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
    always_comb begin
        if (sub) begin
            sum_full = {1'b0, z_op} - ({1'b0, x_op} + {{W_P{1'b0}}, carryin_q});
        end else begin
            sum_full = {1'b0, z_op} + {1'b0, x_op} + {{W_P{1'b0}}, carryin_q};
        end
    end

    // The P register always exists because the X_P/Z_P feedback needs it even when
    // PREG=0; PREG only decides whether the ports see it or the raw adder output.
    dsp_pipe_reg_n #(.WIDTH(W_P+1), .EN(1'b1)) u_p_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_p),
        .d     (sum_full),
        .q     ({carryout_r, p_r})
    );

    assign p         = (PREG != 0) ? p_r : sum_full[W_P-1:0];
    assign carryout  = (PREG != 0) ? carryout_r : sum_full[W_P];
    assign pcout     = p;
    assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed bench for dsp_post_adder_acc: registered instance plus an all-bypass instance.
// Latency: inputs driven 1ns after posedge, outputs sampled just before the next drive.
// Backpressure: n/a.
module tb_dsp_post_adder_acc;

    logic        clk;
    logic        rst_n;
    logic        ce_opmode;
    logic        ce_carryin;
    logic        ce_p;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carryin;

    logic [47:0] p,  pcout;
    logic        carryout,  carryoutf;
    logic [47:0] p0, pcout0;
    logic        carryout0, carryoutf0;

    int errs;
    int checks;

    dsp_post_adder_acc #(.OPMODEREG(1), .CARRYINREG(1), .PREG(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_opmode  (ce_opmode),
        .ce_carryin (ce_carryin),
        .ce_p       (ce_p),
        .opmode     (opmode),
        .m          (m),
        .dab        (dab),
        .c          (c),
        .pcin       (pcin),
        .carryin    (carryin),
        .p          (p),
        .pcout      (pcout),
        .carryout   (carryout),
        .carryoutf  (carryoutf)
    );

    dsp_post_adder_acc #(.OPMODEREG(0), .CARRYINREG(0), .PREG(0)) u_dut_comb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_opmode  (ce_opmode),
        .ce_carryin (ce_carryin),
        .ce_p       (ce_p),
        .opmode     (opmode),
        .m          (m),
        .dab        (dab),
        .c          (c),
        .pcin       (pcin),
        .carryin    (carryin),
        .p          (p0),
        .pcout      (pcout0),
        .carryout   (carryout0),
        .carryoutf  (carryoutf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errs       = 0;
        checks     = 0;
        rst_n      = 1'b1;
        ce_opmode  = 1'b1;
        ce_carryin = 1'b1;
        ce_p       = 1'b1;
        opmode     = 8'($urandom);
        m          = {4'($urandom), 32'($urandom)};
        dab        = {16'($urandom), 32'($urandom)};
        c          = {16'($urandom), 32'($urandom)};
        pcin       = {16'($urandom), 32'($urandom)};
        carryin    = 1'($urandom);

        // 1: reset clears outputs with no clock edge (first posedge is at 5ns)
        #1 rst_n = 1'b0;
        #1;
        chk("rst_p",         64'(p),         64'h0);
        chk("rst_pcout",     64'(pcout),     64'h0);
        chk("rst_carryout",  64'(carryout),  64'h0);
        chk("rst_carryoutf", 64'(carryoutf), 64'h0);

        tick(2);
        chk("rst_held_p", 64'(p), 64'h0);
        rst_n   = 1'b1;
        opmode  = 8'h01;
        m       = 36'h0_0000_0064;
        dab     = '0;
        c       = '0;
        pcin    = '0;
        carryin = 1'b0;

        // 2: multiply pass, opmode takes one edge to register, p one more
        tick(1);
        chk("mul_edge1", 64'(p), 64'h0);
        tick(1);
        chk("mul_edge2", 64'(p), 64'h64);
        chk("mul_pcout", 64'(pcout), 64'h64);

        // 3: accumulate m=5 from p=0
        opmode = 8'h00;
        tick(2);
        chk("acc_clear", 64'(p), 64'h0);
        opmode = 8'h09;
        m      = 36'd5;
        tick(1);
        chk("acc_opm_edge", 64'(p), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("acc_step%0d", k), 64'(p), 64'(5 * k));
        end
        ce_p = 1'b0;
        tick(1);
        chk("acc_hold1", 64'(p), 64'd20);
        tick(1);
        chk("acc_hold2", 64'(p), 64'd20);
        ce_p = 1'b1;

        // 4: subtract with borrow: 3 - (5 + 1)
        opmode  = 8'h8F;
        c       = 48'd3;
        dab     = 48'd5;
        carryin = 1'b1;
        #1;
        chk("sub_comb_p",  64'(p0),        64'h0000_FFFF_FFFF_FFFD);
        chk("sub_comb_co", 64'(carryout0), 64'h1);
        tick(2);
        chk("sub_p",        64'(p),         64'h0000_FFFF_FFFF_FFFD);
        chk("sub_carryout", 64'(carryout),  64'h1);

        // 5: add overflow wraps to zero with carry out
        opmode  = 8'h0F;
        c       = 48'hFFFF_FFFF_FFFF;
        dab     = 48'd1;
        carryin = 1'b0;
        #1;
        chk("ovf_comb_p",   64'(p0),         64'h0);
        chk("ovf_comb_cof", 64'(carryoutf0), 64'h1);
        tick(2);
        chk("ovf_p",         64'(p),         64'h0);
        chk("ovf_carryout",  64'(carryout),  64'h1);
        chk("ovf_carryoutf", 64'(carryoutf), 64'h1);
        chk("ovf_pcout",     64'(pcout),     64'h0);

        // 6: accumulate to 30, then reset between edges
        opmode = 8'h00;
        dab    = '0;
        c      = '0;
        tick(2);
        opmode = 8'h09;
        m      = 36'd5;
        tick(7);
        chk("mid_acc30", 64'(p), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_p",  64'(p),        64'h0);
        chk("mid_rst_co", 64'(carryout), 64'h0);
        #1 rst_n = 1'b1;
        // opmode register held disabled: it must still be the cleared value, so p stays 0
        ce_opmode = 1'b0;
        tick(3);
        chk("mid_opm_cleared", 64'(p), 64'h0);
        ce_opmode = 1'b1;
        tick(1);
        chk("mid_reapply_edge", 64'(p), 64'h0);
        tick(1);
        chk("mid_restart5", 64'(p), 64'd5);
        tick(1);
        chk("mid_restart10", 64'(p), 64'd10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
